// File: rtl/mul_pkg.sv
// Shared definitions for the sequential HI/LO multiply controller:
// FSM encoding, default operand width and counter sizing.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: {upper accumulator, multiplier} shift register fed by a
// WIDTH+1-bit adder; one multiplier bit is retired per step.
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 negate_i,
  input  logic [WIDTH-1:0]     ua_i,
  input  logic [WIDTH-1:0]     ub_i,
  output logic [2*WIDTH-1:0]   product_o
);

  logic [WIDTH-1:0]   ua_q, ua_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, ua_q} : '0);
    ua_d = ua_q;
    p_d  = p_q;
    if (load_i) begin
      ua_d = ua_i;
      p_d  = {{WIDTH{1'b0}}, ub_i};
    end else if (step_i) begin
      // Carry lands in the top bit as the whole register shifts right.
      p_d = {sum, p_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ua_q <= '0;
      p_q  <= '0;
    end else begin
      ua_q <= ua_d;
      p_q  <= p_d;
    end
  end

  assign product_o = negate_i ? -p_q : p_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MULT/MULTU controller for the HI/LO unit: sequences the
// shift-add datapath, applies sign correction and services MTHI/MTLO.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mul_state_e       dbg_state
);

  localparam int CNT_W = cnt_width(WIDTH);

  mul_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   ua_mag, ub_mag;
  logic [2*WIDTH-1:0] product;
  logic               accept;

  // Two's complement of the most negative value is itself, which is the
  // correct unsigned magnitude, so no extra bit is needed.
  assign ua_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign ub_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign accept = (state_q == ST_IDLE) && start && !abort;

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (accept),
    .step_i    (state_q == ST_CALC),
    .negate_i  (neg_q),
    .ua_i      (ua_mag),
    .ub_i      (ub_mag),
    .product_o (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (accept) begin
            neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            {hi_q, lo_q} <= product;
            done_q       <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: hand-computed products, latency, abort,
// MTHI/MTLO and asynchronous reset behaviour.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         abort = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  mul_state_e   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2*W-1:0] exp_q[$];
  logic busy_after;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .abort(abort), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives a start for one edge (E0); returns #1 after E0.
  task automatic start_mul(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
    @(negedge clk);
    a = aa; b = bb; is_signed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Steps n edges after E0; pops the scoreboard on each done pulse.
  task automatic run_edges(input int n, input bit poke, output int pulses, output int first);
    pulses = 0;
    first = 0;
    busy_after = 1'b1;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      if (poke) begin
        start = (e >= 3 && e <= 6);
        a = 32'hFFFF_FFFF; b = 32'h0000_0003;
      end
      if (first != 0 && e == first + 1) busy_after = busy;
      if (done) begin
        pulses++;
        if (first == 0) first = e;
        if (exp_q.size() > 0) check("product", {hi, lo}, exp_q.pop_front());
        else check("unexpected_done", 1, 0);
      end
    end
    start = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic s, input logic [2*W-1:0] exp, input bit poke);
    int pulses, first;
    start_mul(aa, bb, s);
    exp_q.push_back(exp);
    run_edges(37, poke, pulses, first);
    check({tag, "_latency"}, first, 33);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_busy_after"}, busy_after, 0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int pulses, first, dones;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk) reset = 1'b0;

    run_mul("u_zero",   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b0);
    run_mul("u_ffff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_mul("s_m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
    run_mul("s_min_aa", 32'h8000_0000, 32'hAAAA_AAAA, 1'b1, 64'h2AAA_AAAB_0000_0000, 1'b0);
    run_mul("u_min_aa", 32'h8000_0000, 32'hAAAA_AAAA, 1'b0, 64'h5555_5555_0000_0000, 1'b0);
    run_mul("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
    run_mul("u_45x104", 32'd45, 32'd104, 1'b0, 64'h0000_0000_0000_1248, 1'b1);

    // MTHI/MTLO preload, then aborted multiply
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    check("pre_hi", hi, 32'h1234);
    check("pre_lo", lo, 32'h5678);

    start_mul(32'd7, 32'd14, 1'b0);
    check("calc_state", dbg_state, ST_CALC);
    dones = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, ST_IDLE);
    for (int e = 0; e < 4; e++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", dones, 0);
    check("abort_hi", hi, 32'h1234);
    check("abort_lo", lo, 32'h5678);

    // MTHI while busy is ignored; the multiply then completes
    start_mul(32'd7, 32'd14, 1'b0);
    exp_q.push_back(64'h62);
    @(posedge clk);
    #1 mthi = 1'b1; wdata = 32'hFFFF;
    @(posedge clk);
    #1 mthi = 1'b0;
    check("busy_mthi_hi", hi, 32'h1234);
    run_edges(36, 1'b0, pulses, first);
    check("busy_mthi_pulses", pulses, 1);
    check("busy_mthi_sb", exp_q.size(), 0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    mthi = 1'b0;
    check("pre_rst_hi", hi, 32'hDEAD);
    start_mul(32'h47, 32'h0E, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, ST_IDLE);
    @(negedge clk) reset = 1'b0;
    run_mul("post_rst", 32'h47, 32'h0E, 1'b0, 64'h3E2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
